// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - host preload/reset/run/report sequencer; optional timeout via RUN_SEQ_TIMEOUT_EN
module run_sequencer #(
    parameter int AW        = 8,
    parameter int CW        = 16,
    parameter int RST_CYC   = 4,
    parameter int TMO_LIMIT = 16'd4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat,
    output logic          busy_load,
    output logic          cpu_reset,
    input  logic          cpu_done,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RST,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_LIMIT - 1);
    localparam logic [3:0]    RST_LD   = 4'(RST_CYC - 1);

`ifdef RUN_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rst_cnt;
    logic       beat;
    logic       tmo_hit;

    assign beat    = ld_valid && ld_ready;
    // Timeout fires on the RUN cycle that would bring the count up to TMO_LIMIT.
    assign tmo_hit = TMO_EN && (cycles == TMO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived handshake/ownership outputs.
    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        busy_load = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready  = 1'b1;
                busy_load = 1'b1;
                if (ld_valid && ld_last) begin
                    state_nxt = S_RST;
                end
            end
            S_RST: begin
                // The final preload write lands in the first RST cycle; keep the port until it has.
                busy_load = mem_wr_en;
                if (rst_cnt == 4'd0) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                cpu_reset = 1'b0;
                if (cpu_done || tmo_hit) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done = 1'b1;
                if (!req) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Preload write pipeline, reset hold counter, run cycle counter and timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_dat   <= '0;
            rst_cnt   <= '0;
            cycles    <= '0;
            timeout   <= 1'b0;
        end else begin
            mem_wr_en <= beat;
            if (beat) begin
                mem_addr <= ld_addr;
                mem_dat  <= ld_data;
            end
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cycles  <= '0;
                        timeout <= 1'b0;
                    end
                end
                S_LOAD: begin
                    rst_cnt <= RST_LD;
                end
                S_RST: begin
                    rst_cnt <= rst_cnt - 4'd1;
                end
                S_RUN: begin
                    // The cycle on which cpu_done is seen is not counted.
                    if (!cpu_done) begin
                        if (!(&cycles)) begin
                            cycles <= cycles + CW'(1);
                        end
                        if (tmo_hit) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - self-checking bench for run_sequencer
module tb_run_sequencer;

    localparam int AW        = 8;
    localparam int CW        = 16;
    localparam int RST_CYC   = 4;
    localparam int TMO_LIMIT = 4000;
    localparam int CMAX      = (1 << CW) - 1;
`ifdef RUN_SEQ_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic          ld_last = 1'b0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dat;
    logic          busy_load;
    logic          cpu_reset;
    logic          cpu_done = 1'b0;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;

    always #5 clk = ~clk;

    run_sequencer #(
        .AW(AW), .CW(CW), .RST_CYC(RST_CYC), .TMO_LIMIT(TMO_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .req(req),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat(mem_dat),
        .busy_load(busy_load), .cpu_reset(cpu_reset), .cpu_done(cpu_done),
        .done(done), .timeout(timeout), .cycles(cycles)
    );

    int n_cmp = 0;
    int n_err = 0;
    int b_addr[$];
    int b_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_cycles"}, cycles, 0);
        chk({tag, "_wr_en"}, mem_wr_en, 0);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_busy"}, busy_load, 0);
    endtask

    // One host transaction: preload the beats in b_addr/b_data, run, report, release.
    // done_at: RUN cycle on which cpu_done is raised (0 = never).
    task automatic do_txn(input int done_at, input bit gappy, input bit drop_req,
                          input bit spurious, input int abort_at, input int hold_fin);
        int t = 0;
        int beat_i = 0;
        int run_n = 0;
        int load_start = -1;
        int first_run = -1;
        int last_acc = -1;
        int last_wr = -1;
        int busy_n = 0;
        int rdy_n = 0;
        int nb;
        int exp_run;
        int exp_cyc;
        bit exp_tmo;
        bit fin = 1'b0;
        bit tog = 1'b0;
        int acc_t[$];
        int wr_t[$];
        int wr_a[$];
        int wr_d[$];
        logic [7:0] mem_exp[int];
        logic [7:0] mem_got[int];
        logic [31:0] got_v;

        nb = b_addr.size();
        @(negedge clk);
        req = 1'b1;
        cpu_done = spurious;
        while (!fin && t < 80000) begin
            @(negedge clk);
            t++;
            if (mem_wr_en === 1'b1) begin
                wr_t.push_back(t);
                wr_a.push_back(int'(mem_addr));
                wr_d.push_back(int'(mem_dat));
                mem_got[int'(mem_addr)] = mem_dat;
                last_wr = t;
            end
            if (busy_load === 1'b1) busy_n++;
            if (ld_ready === 1'b1) begin
                rdy_n++;
                if (load_start < 0) load_start = t;
            end
            if (cpu_reset === 1'b0) begin
                run_n++;
                if (first_run < 0) first_run = t;
            end
            if (done === 1'b1) fin = 1'b1;

            if (abort_at > 0 && run_n == abort_at) begin
                reset = 1'b0;
                req = 1'b0;
                ld_valid = 1'b0;
                cpu_done = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    idle_checks("abort_rst");
                end
                reset = 1'b1;
                @(negedge clk);
                idle_checks("abort_idle");
                return;
            end

            ld_valid = 1'b0;
            ld_last = 1'b0;
            if (beat_i < nb) begin
                tog = ~tog;
                ld_valid = gappy ? tog : 1'b1;
                ld_addr = AW'(b_addr[beat_i]);
                ld_data = 8'(b_data[beat_i]);
                ld_last = (beat_i == nb - 1);
                if (ld_valid && ld_ready) begin
                    acc_t.push_back(t);
                    mem_exp[b_addr[beat_i]] = 8'(b_data[beat_i]);
                    beat_i++;
                    last_acc = t;
                end
            end else if (!gappy && run_n == 0) begin
                ld_valid = 1'b1;
                ld_addr = AW'($urandom_range(0, 255));
                ld_data = 8'($urandom_range(0, 255));
                ld_last = 1'($urandom_range(0, 1));
            end

            if (run_n == 0) cpu_done = spurious;
            else cpu_done = (done_at > 0 && run_n == done_at);
            if (drop_req && run_n >= 1) req = 1'b0;
        end
        cpu_done = 1'b0;
        ld_valid = 1'b0;
        chk("run_finished", 32'(fin), 1);
        if (!fin) return;

        if (TMO_ON && (done_at == 0 || done_at > TMO_LIMIT)) begin
            exp_run = TMO_LIMIT;
            exp_tmo = 1'b1;
            exp_cyc = TMO_LIMIT;
        end else begin
            exp_run = done_at;
            exp_tmo = 1'b0;
            exp_cyc = (done_at - 1 > CMAX) ? CMAX : done_at - 1;
        end
        chk("run_len", run_n, exp_run);
        chk("timeout", timeout, 32'(exp_tmo));
        chk("cycles", cycles, exp_cyc);
        chk("n_writes", wr_t.size(), nb);
        for (int i = 0; i < nb && i < wr_t.size() && i < acc_t.size(); i++) begin
            chk("wr_latency", wr_t[i] - acc_t[i], 1);
            chk("wr_addr", wr_a[i], b_addr[i]);
            chk("wr_data", wr_d[i], b_data[i]);
        end
        chk("rst_len", first_run - last_wr, RST_CYC);
        chk("busy_len", busy_n, last_wr - load_start + 1);
        chk("ready_len", rdy_n, last_acc - load_start + 1);
        foreach (mem_exp[a]) begin
            got_v = mem_got.exists(a) ? 32'(mem_got[a]) : 32'hffff_ffff;
            chk("mem_content", got_v, 32'(mem_exp[a]));
        end
        repeat (hold_fin) begin
            @(negedge clk);
            chk("fin_hold_done", done, 1);
            chk("fin_hold_cycles", cycles, exp_cyc);
            chk("fin_hold_cpu_reset", cpu_reset, 1);
        end
        req = 1'b0;
        @(negedge clk);
        chk("release_done", done, 0);
        chk("release_cpu_reset", cpu_reset, 1);
    endtask

    task automatic rand_beats(input int nb);
        b_addr.delete();
        b_data.delete();
        for (int i = 0; i < nb; i++) begin
            b_addr.push_back($urandom_range(0, 7));
            b_data.push_back($urandom_range(0, 255));
        end
    endtask

    initial begin
        int rdrop;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        idle_checks("por");
        reset = 1'b1;
        @(negedge clk);
        idle_checks("por_idle");

        b_addr = '{32'h00, 32'h05, 32'h05};
        b_data = '{32'h11, 32'h22, 32'h33};
        do_txn(37, 1'b0, 1'b0, 1'b0, 0, 3);

        rand_beats(1);
        do_txn($urandom_range(5, 50), 1'b1, 1'b1, 1'b0, 0, 0);

        rand_beats(3);
        do_txn(20, 1'b0, 1'b0, 1'b1, 0, 1);

        rand_beats(2);
        do_txn(0, 1'b0, 1'b0, 1'b0, 10, 0);

        for (int k = 0; k < 8; k++) begin
            rand_beats($urandom_range(1, 6));
            rdrop = $urandom_range(0, 1);
            do_txn($urandom_range(1, 60), 1'($urandom_range(0, 1)), 1'(rdrop),
                   1'($urandom_range(0, 1)), 0, rdrop ? 0 : $urandom_range(0, 3));
        end

`ifdef RUN_SEQ_TIMEOUT_EN
        rand_beats(2);
        do_txn(0, 1'b0, 1'b0, 1'b0, 0, 2);
        rand_beats(1);
        do_txn(TMO_LIMIT, 1'b0, 1'b0, 1'b0, 0, 0);
`else
        rand_beats(2);
        do_txn(CMAX + 5, 1'b0, 1'b0, 1'b0, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Host-side sequencer directly upstream of the CPU top level.
- Accepts a host start request and a byte stream of data-memory preload writes. Holds the CPU in reset while it writes the bytes into data memory, then releases the CPU and times the run until the CPU raises done.
- Reports completion, timeout and cycle count back to the host with a 4-phase req/done handshake.
- Owns the data-memory write port only while loading; the CPU owns it otherwise (mux external to this block, select = busy_load).

Parameters:
AW, 8, data-memory address width
CW, 16, run cycle counter width
RST_CYC, 4, cycles CPU reset is held after load completes (1..15)
TMO_LIMIT, 16'd4000, run cycles before timeout (must be < 2**CW)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  1  host start request, level (4-phase)
ld_valid  in  1  preload beat valid
ld_ready  out  1  preload beat accepted when ld_valid&ld_ready
ld_addr  in  AW  preload byte address
ld_data  in  8  preload byte
ld_last  in  1  marks final preload beat
mem_wr_en  out  1  data-memory write strobe
mem_addr  out  AW  data-memory write address
mem_dat  out  8  data-memory write data
busy_load  out  1  high while sequencer owns data-memory port
cpu_reset  out  1  active-high reset to CPU top level
cpu_done  in  1  CPU done flag
done  out  1  host completion flag
timeout  out  1  run ended by timeout (valid while done=1)
cycles  out  CW  RUN cycles elapsed, saturating

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - cpu_reset=1; done=0; timeout=0; cycles=0; mem_wr_en=0; mem_addr=0; mem_dat=0; ld_ready=0; busy_load=0.
  - Reset mid-operation aborts immediately. No further memory writes are issued.
- States:
  - IDLE: cpu_reset=1, ld_ready=0. req==1 -> LOAD; cycles and timeout clear on that transition.
  - LOAD: ld_ready=1, busy_load=1, cpu_reset=1.
    - Each accepted beat registers mem_wr_en=1, mem_addr=ld_addr, mem_dat=ld_data on the next cycle (1-cycle latency). mem_wr_en=0 on cycles with no accepted beat.
    - Beat with ld_last=1 -> RST. ld_ready drops in RST.
    - The final write still issues in the first RST cycle; busy_load stays 1 through that cycle.
  - RST: cpu_reset=1 for exactly RST_CYC cycles (down-counter), then -> RUN.
  - RUN: cpu_reset=0.
    - cycles increments every RUN cycle, saturating at all-ones.
    - cpu_done==1 -> FIN with timeout=0; that cycle is not counted.
    - Else, cycles==TMO_LIMIT-1 at the clock edge -> FIN with timeout=1, cycles=TMO_LIMIT.
    - cpu_done has priority over timeout in the same cycle.
  - FIN: done=1, cpu_reset=1 (freezes CPU; data memory retained). cycles and timeout hold. req==0 -> IDLE, done=0 next cycle.
- req deasserted during LOAD/RST/RUN is ignored; the sequence runs to FIN.
- req held high in FIN keeps done=1 indefinitely.
- A zero-beat load is not supported: at least one beat with ld_last is required. ld_last on the first beat is legal.
- Repeated writes to the same address in one load: the last beat wins.
- cpu_done sampled before RUN is ignored.

Optional Feature:
- Macro: RUN_SEQ_TIMEOUT_EN.
- Defined: timeout behaviour as above.
- Undefined:
  - No timeout path.
  - timeout output tied 0.
  - RUN exits only on cpu_done.
  - cycles still counts and saturates.

Test Plan:
- Reset held 3 cycles mid-RUN -> next cycle state IDLE, cpu_reset=1, done=0, cycles=0, no mem_wr_en.
- req=1, 3 beats (0x00<-0x11, 0x05<-0x22, 0x05<-0x33 last), ld_valid always high:
  - mem_wr_en high exactly 3 cycles, each one cycle after its beat.
  - Address 0x05 ends with 0x33.
  - cpu_reset stays high RST_CYC=4 cycles after the last write.
- Full run, cpu_done raised on the 37th RUN cycle -> done=1, timeout=0, cycles=36. Drop req -> done=0 the following cycle.
- cpu_done never raised, RUN_SEQ_TIMEOUT_EN defined -> done=1, timeout=1, cycles=4000 after 4000 RUN cycles. Same stimulus without the macro -> done stays 0, cycles saturates at 65535.
- ld_valid toggled 1/0 with single-beat load (ld_last on first beat):
  - One write only.
  - ld_ready=0 from the cycle after acceptance.
  - req dropped during RUN: run still completes to done=1.
- cpu_done=1 forced during IDLE/LOAD -> ignored. cpu_done and timeout boundary coincide -> timeout=0.
